// File: rtl/pipe_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_pkg
// Shared definitions for the elastic pipeline stage register.
//   pipe_state_t : occupancy of the stage
//                    EMPTY = nothing held
//                    MAIN  = main entry valid
//                    BOTH  = main and skid entries valid (skid build only)
//   RESET        : level of rst that resets the stage
//   state_count  : number of entries held in a given state
// ---------------------------------------------------------------------------
package pipe_stage_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MAIN  = 2'd1,
      BOTH  = 2'd2
   } pipe_state_t;

   localparam logic RESET = 1'b1;

   // Occupancy of each state, used to drive the entry count output.
   function automatic logic [1:0] state_count(input pipe_state_t s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         EMPTY:   n = 2'd0;
         MAIN:    n = 2'd1;
         BOTH:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage
// Elastic pipeline stage register. It carries a data payload and a
// control-bit vector from one pipeline stage to the next, using a
// valid/ready handshake on both sides. It supports flush, and it zeroes
// the control bits whenever it presents a bubble. With SKID=1 a second
// (skid) entry absorbs the transfer that is in flight when the downstream
// stage stalls. This lets o_ready depend on the state register alone.
//
// Parameters
//   DATA_WIDTH : payload width
//   CTRL_WIDTH : control-bit vector width
//   SKID       : 1 = two entries, registered ready; 0 = one entry,
//                combinational ready
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   i_valid  in   upstream offers an entry
//   o_ready  out  stage can accept this cycle
//   i_data   in   upstream payload
//   i_ctrl   in   upstream control bits
//   i_flush  in   discard everything held; drop this cycle's input
//   o_valid  out  stage presents an entry
//   i_ready  in   downstream accepts this cycle
//   o_data   out  presented payload (holds its last value across bubbles)
//   o_ctrl   out  presented control bits, zero whenever o_valid=0
//   o_count  out  entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage
   import pipe_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = 5,
   parameter int SKID       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic [CTRL_WIDTH-1:0] i_ctrl,
   input  logic                  i_flush,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CTRL_WIDTH-1:0] o_ctrl,
   output logic [1:0]            o_count
);

   pipe_state_t           state_q;
   pipe_state_t           next_state;

   logic [DATA_WIDTH-1:0] main_data_q;
   logic [CTRL_WIDTH-1:0] main_ctrl_q;
   logic [DATA_WIDTH-1:0] skid_data_q;
   logic [CTRL_WIDTH-1:0] skid_ctrl_q;

   logic                  accept;
   logic                  take;
   logic                  load_main_in;
   logic                  load_main_skid;
   logic                  load_skid;

   assign o_valid = (state_q != EMPTY);

   // The skid build decodes ready from the state register only, so a
   // downstream stall cannot ripple combinationally upstream. The
   // single-register build must look at i_ready. It can refill in the
   // same cycle that it drains, which keeps back-to-back transfers
   // without a gap.
   generate
      if (SKID != 0) begin : g_ready_reg
         assign o_ready = (state_q != BOTH);
      end else begin : g_ready_comb
         assign o_ready = i_ready | ~o_valid;
      end
   endgenerate

   assign accept  = i_valid & o_ready;
   assign take    = o_valid & i_ready;

   assign o_data  = main_data_q;
   assign o_ctrl  = o_valid ? main_ctrl_q : '0;
   assign o_count = state_count(state_q);

   // Next-state logic and selection of which register loads.
   // Flush sends the stage to EMPTY and suppresses every load, so an
   // entry accepted in the flush cycle is dropped. In the single-register
   // build, MAIN with accept but no take cannot happen, because there
   // o_ready equals i_ready.
   always_comb begin
      next_state     = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;

      if (i_flush) begin
         next_state = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  next_state   = MAIN;
                  load_main_in = 1'b1;
               end
            end
            MAIN: begin
               if (accept && take) begin
                  load_main_in = 1'b1;
               end else if (accept && !take) begin
                  if (SKID != 0) begin
                     next_state = BOTH;
                     load_skid  = 1'b1;
                  end
               end else if (take) begin
                  next_state = EMPTY;
               end
            end
            BOTH: begin
               if (take) begin
                  next_state     = MAIN;
                  load_main_skid = 1'b1;
               end
            end
            default: begin
               next_state = EMPTY;
            end
         endcase
      end
   end

   // State and entry registers. Reset takes priority over flush and over
   // any handshake. Flush clears the held control bits but keeps the
   // payload, so o_data does not toggle across the resulting bubble.
   always_ff @(posedge clk) begin
      if (rst == RESET) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q <= next_state;
         if (i_flush) begin
            main_ctrl_q <= '0;
            skid_ctrl_q <= '0;
         end else begin
            if (load_main_in) begin
               main_data_q <= i_data;
               main_ctrl_q <= i_ctrl;
            end else if (load_main_skid) begin
               main_data_q <= skid_data_q;
               main_ctrl_q <= skid_ctrl_q;
            end
            if (load_skid) begin
               skid_data_q <= i_data;
               skid_ctrl_q <= i_ctrl;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage
// Drives a SKID=1 and a SKID=0 instance of pipe_stage with the same inputs.
// Each instance is compared with its own queue-based model: a FIFO of
// capacity 2 or 1. The bench runs directed scenarios first and then a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_pipe_stage;

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  ctrl;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [63:0] i_data;
   logic [4:0]  i_ctrl;
   logic        i_flush;
   logic        i_ready;

   logic        o_ready1, o_valid1;
   logic [63:0] o_data1;
   logic [4:0]  o_ctrl1;
   logic [1:0]  o_count1;

   logic        o_ready0, o_valid0;
   logic [63:0] o_data0;
   logic [4:0]  o_ctrl0;
   logic [1:0]  o_count0;

   int          checks = 0;
   int          errors = 0;

   entry_t      q1[$];
   entry_t      q0[$];
   logic [63:0] last1 = '0;
   logic [63:0] last0 = '0;
   bit          modelKnown = 1'b0;

   always #5 clk = ~clk;

   pipe_stage #(.DATA_WIDTH(64), .CTRL_WIDTH(5), .SKID(1)) dut1 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready1),
      .i_data(i_data), .i_ctrl(i_ctrl), .i_flush(i_flush),
      .o_valid(o_valid1), .i_ready(i_ready), .o_data(o_data1),
      .o_ctrl(o_ctrl1), .o_count(o_count1)
   );

   pipe_stage #(.DATA_WIDTH(64), .CTRL_WIDTH(5), .SKID(0)) dut0 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready0),
      .i_data(i_data), .i_ctrl(i_ctrl), .i_flush(i_flush),
      .o_valid(o_valid0), .i_ready(i_ready), .o_data(o_data0),
      .o_ctrl(o_ctrl0), .o_count(o_count0)
   );

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of inputs. It checks ready before the edge, advances
   // both FIFO models, and checks every registered output after the edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [63:0] d,
                                input logic [4:0] c, input logic f, input logic rdy);
      bit     rdy1, rdy0, acc1, acc0, tk1, tk0;
      entry_t e;
      rst     = r;
      i_valid = v;
      i_data  = d;
      i_ctrl  = c;
      i_flush = f;
      i_ready = rdy;
      #1;
      rdy1 = (q1.size() < 2);
      rdy0 = rdy || (q0.size() == 0);
      if (modelKnown) begin
         checkOutput("skid1_ready", {63'd0, o_ready1}, {63'd0, rdy1});
         checkOutput("skid0_ready", {63'd0, o_ready0}, {63'd0, rdy0});
      end
      acc1 = v && rdy1;
      acc0 = v && rdy0;
      tk1  = (q1.size() > 0) && rdy;
      tk0  = (q0.size() > 0) && rdy;
      e.data = d;
      e.ctrl = c;
      @(posedge clk);
      #1;
      if (r) begin
         q1.delete();
         q0.delete();
         last1 = '0;
         last0 = '0;
         modelKnown = 1'b1;
      end else if (f) begin
         q1.delete();
         q0.delete();
      end else begin
         if (tk1) void'(q1.pop_front());
         if (acc1) q1.push_back(e);
         if (tk0) void'(q0.pop_front());
         if (acc0) q0.push_back(e);
      end
      if (q1.size() > 0) last1 = q1[0].data;
      if (q0.size() > 0) last0 = q0[0].data;
      if (modelKnown) begin
         checkOutput("skid1_valid", {63'd0, o_valid1}, {63'd0, q1.size() > 0});
         checkOutput("skid1_count", {62'd0, o_count1}, 64'(q1.size()));
         checkOutput("skid1_data", o_data1, last1);
         checkOutput("skid1_ctrl", {59'd0, o_ctrl1},
                     (q1.size() > 0) ? {59'd0, q1[0].ctrl} : 64'd0);
         checkOutput("skid0_valid", {63'd0, o_valid0}, {63'd0, q0.size() > 0});
         checkOutput("skid0_count", {62'd0, o_count0}, 64'(q0.size()));
         checkOutput("skid0_data", o_data0, last0);
         checkOutput("skid0_ctrl", {59'd0, o_ctrl0},
                     (q0.size() > 0) ? {59'd0, q0[0].ctrl} : 64'd0);
      end
   endtask

   initial begin
      // Reset for two cycles, then stream three entries at full rate.
      applyStimulus(1, 0, 64'h0, 5'h00, 0, 1);
      applyStimulus(1, 0, 64'h0, 5'h00, 0, 1);
      checkOutput("reset_data", o_data1, 64'h0);
      applyStimulus(0, 1, 64'h1, 5'h01, 0, 1);
      applyStimulus(0, 1, 64'h2, 5'h02, 0, 1);
      applyStimulus(0, 1, 64'h3, 5'h03, 0, 1);
      checkOutput("stream_last", o_data1, 64'h3);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);

      // Downstream stall fills the skid entry, then both drain in order.
      applyStimulus(0, 1, 64'hA, 5'h0A, 0, 0);
      applyStimulus(0, 1, 64'hB, 5'h0B, 0, 0);
      checkOutput("stall_count", {62'd0, o_count1}, 64'd2);
      checkOutput("stall_held", o_data1, 64'hA);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);
      checkOutput("drain_second", o_data1, 64'hB);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);

      // A bubble between two valid entries must zero the control bits.
      applyStimulus(0, 1, 64'h11, 5'h1F, 0, 1);
      applyStimulus(0, 0, 64'h99, 5'h1F, 0, 1);
      checkOutput("bubble_ctrl", {59'd0, o_ctrl1}, 64'd0);
      checkOutput("bubble_data", o_data1, 64'h11);
      applyStimulus(0, 1, 64'h12, 5'h1F, 0, 1);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);

      // Flush while both entries are held, with a new offer in the same cycle.
      applyStimulus(0, 1, 64'h21, 5'h1F, 0, 0);
      applyStimulus(0, 1, 64'h22, 5'h1F, 0, 0);
      applyStimulus(0, 1, 64'hC, 5'h1F, 1, 0);
      checkOutput("flush_count", {62'd0, o_count1}, 64'd0);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);

      // Reset while both entries are held.
      applyStimulus(0, 1, 64'hD, 5'h0D, 0, 0);
      applyStimulus(0, 1, 64'hE, 5'h0E, 0, 0);
      applyStimulus(1, 0, 64'h0, 5'h00, 0, 0);
      checkOutput("midreset_data", o_data1, 64'h0);
      applyStimulus(0, 0, 64'h0, 5'h00, 0, 1);

      // Randomized traffic with occasional flush and reset.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 9) < 7),
                       {$urandom, $urandom},
                       5'($urandom),
                       ($urandom_range(0, 29) == 0),
                       ($urandom_range(0, 9) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised elastic pipeline stage register for the RISC-V core: the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries an arbitrary data payload plus a control-bit vector between two stages. It adds a valid/ready handshake, stall back-pressure, flush, and bubble insertion that forces control bits to zero. An optional two-entry skid buffer registers the upstream ready so stalls do not form a combinational path through the whole pipeline.

## Interface
- DATA_WIDTH, default 64: payload width (operands, immediate, rd select, funct fields packed by the instantiating stage).
- CTRL_WIDTH, default 5: control-bit vector width (mem_write, mem_read, mem_to_reg, reg_wr_en, alu_src, ...).
- SKID, default 1: 1 = two-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  upstream holds a valid entry.
- o_ready  output  1  stage can accept this cycle.
- i_data  input  DATA_WIDTH  upstream payload.
- i_ctrl  input  CTRL_WIDTH  upstream control bits.
- i_flush  input  1  discard all held entries (branch/exception redirect).
- o_valid  output  1  stage presents a valid entry.
- i_ready  input  1  downstream accepts this cycle.
- o_data  output  DATA_WIDTH  presented payload.
- o_ctrl  output  CTRL_WIDTH  presented control bits; all zero whenever o_valid=0.
- o_count  output  2  entries held (0..2; never 2 when SKID=0).

## Operation
- accept = i_valid & o_ready; take = o_valid & i_ready.
- States (pipe_state_t): EMPTY, MAIN (main entry valid), BOTH (main and skid valid; SKID=1 only).
- EMPTY: accept -> MAIN, main <= input.
- MAIN: accept & take -> MAIN, main <= input. accept & !take -> BOTH, skid <= input. !accept & take -> EMPTY. Otherwise hold.
- BOTH: o_ready=0. take -> MAIN, main <= skid. Otherwise hold.
- SKID=0: states EMPTY/MAIN only. o_ready = i_ready | !o_valid (combinational). MAIN with accept & !take cannot occur.
- SKID=1: o_ready = (state != BOTH), driven from the state register; no combinational dependency on i_ready.
- o_valid = (state != EMPTY). o_data/o_ctrl come from the main entry.
- Bubble gating: o_ctrl = '0 whenever o_valid=0. o_data holds its last value (no toggling).
- Flush: i_flush=1 -> next state EMPTY regardless of accept/take. An input accepted in the same cycle is dropped. Entries are cleared, and o_ctrl reads 0 next cycle. o_ready still reflects the current state during the flush cycle.
- Reset: rst=1 -> next state EMPTY, main/skid data and ctrl <= 0. Reset overrides flush and any handshake. A mid-transfer entry is lost.
- Held entry is stable: while o_valid=1 & i_ready=0, o_data/o_ctrl do not change.

## Timing
- Reset values (cycle after rst sampled high): o_valid=0, o_data=0, o_ctrl=0, o_count=0. o_ready=1 (SKID=1). For SKID=0, o_ready = 1 because o_valid=0.
- Latency: input accepted at edge N appears on o_data/o_valid after edge N (1 cycle), when EMPTY or MAIN with take.
- Throughput: 1 entry/cycle with i_ready held high; no bubble inserted by the stage itself.
- SKID=1: o_ready deasserts one cycle after downstream stall begins with a pending input. The skid entry absorbs that in-flight transfer; no loss, no duplication.
- Order: strict FIFO; skid entry always leaves after the main entry.

## Structure
- Package common: pipe_state_t enum (EMPTY, MAIN, BOTH) and reset polarity constant RESET=1'b1.
- Single module, no sub-module. Stage-specific wrappers (if_id, id_ex, ex_mem, mem_wb) pack/unpack their fields into i_data/i_ctrl and instantiate pipe_stage.

## Test plan
- Reset then stream: rst 2 cycles; i_valid=1, i_ready=1, data 0x1,0x2,0x3 on consecutive cycles -> o_data 0x1,0x2,0x3 one cycle later each; o_count stays 1; o_ready=1 throughout.
- Stall with skid (SKID=1): offer 0xA then 0xB with i_ready=0 -> o_count 2, o_ready=0, o_data=0xA held. Raise i_ready -> 0xA then 0xB delivered in order, o_ready=1 after 0xA leaves.
- Bubble gating: i_ctrl=5'b11111, i_valid=0 for one cycle between two valid entries -> o_valid=0 and o_ctrl=5'b00000 in that cycle; o_data unchanged.
- Flush in BOTH with simultaneous i_valid=1 (data 0xC) -> next cycle o_valid=0, o_count=0, o_ctrl=0; 0xC never appears at output.
- Reset mid-operation: state BOTH holding 0xD/0xE, assert rst one cycle -> all outputs at reset values next cycle; neither entry delivered.
- SKID=0 instance: i_ready=0 with entry held -> o_ready=0 same cycle. i_ready=1 with i_valid=1 -> o_ready=1 combinationally, back-to-back transfer without gap.
